// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clk_div_mode_e;

  localparam int unsigned CLK_DIV_DEFAULT_DIV = 25_000_000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/shadow divisor pair, tick and derived clock.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  clk_div_mode_e    i_mode,
  input  logic             i_sync,
  input  logic             i_wr_stb,
  input  logic [DIV_W-1:0] i_wr_data,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic             o_pending
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_tgl;
  logic             r_clk_out;

  logic             w_halted;
  logic             w_boundary;
  logic             w_apply;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_tick_nxt;
  logic             w_tgl_nxt;

  assign w_halted   = (r_div_act == '0);
  // The halted term keeps the div_act-1 compare from ever seeing an underflowed value.
  assign w_boundary = i_en && !i_sync && !w_halted && (r_cnt == r_div_act - DIV_W'(1));
  assign w_apply    = r_pending && (w_boundary || !i_en || i_sync || w_halted);

  always_comb begin
    w_cnt_nxt  = r_cnt + DIV_W'(1);
    w_tick_nxt = 1'b0;
    w_tgl_nxt  = r_tgl;
    if (!i_en || i_sync) begin
      w_cnt_nxt = '0;
      w_tgl_nxt = 1'b0;
    end else if (w_halted) begin
      w_cnt_nxt = '0;
    end else if (w_boundary) begin
      w_cnt_nxt  = '0;
      w_tick_nxt = 1'b1;
      w_tgl_nxt  = ~r_tgl;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_div_act <= DIV_W'(DEFAULT_DIV);
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_tgl     <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_tick    <= w_tick_nxt;
      r_tgl     <= w_tgl_nxt;
      r_clk_out <= (i_mode == MODE_PULSE) ? w_tick_nxt : w_tgl_nxt;
      // A write can only be accepted while nothing is pending, so it never collides with an apply.
      if (w_apply) begin
        r_div_act <= r_shadow;
        r_pending <= 1'b0;
      end else if (i_wr_stb) begin
        r_shadow  <= i_wr_data;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_out = r_clk_out;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: divisor write-port decode, ready mux and channel array.
// Optional macro CLK_DIV_MULTI_SYNC_EN adds i_sync_in to re-phase all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic                              i_sync_in,
`endif
  input  logic [NUM_CH-1:0]                 i_en,
  input  logic [NUM_CH-1:0]                 i_mode,
  input  logic                              i_div_wr_valid,
  output logic                              o_div_wr_ready,
  input  logic [($clog2(NUM_CH) | 1)-1:0]   i_div_wr_ch,
  input  logic [DIV_W-1:0]                  i_div_wr_data,
  output logic [NUM_CH-1:0]                 o_tick,
  output logic [NUM_CH-1:0]                 o_clk_out
);

  localparam int unsigned CH_W = $clog2(NUM_CH) | 1;

  logic [NUM_CH-1:0] w_pending;
  logic              w_accept;
  logic              w_sync;

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign w_sync = i_sync_in;
`else
  assign w_sync = 1'b0;
`endif

  // Out-of-range channel indices are always ready and the data is dropped.
  always_comb begin
    o_div_wr_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_div_wr_ch == CH_W'(i)) o_div_wr_ready = ~w_pending[i];
    end
  end

  assign w_accept = i_div_wr_valid & o_div_wr_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en[g]),
      .i_mode    (clk_div_mode_e'(i_mode[g])),
      .i_sync    (w_sync),
      .i_wr_stb  (w_accept && (i_div_wr_ch == CH_W'(g))),
      .i_wr_data (i_div_wr_data),
      .o_tick    (o_tick[g]),
      .o_clk_out (o_clk_out[g]),
      .o_pending (w_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: per-cycle model comparison plus directed literal checks.
module tb_clk_div_multi;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int DEF    = 4;
  localparam int CH_W   = $clog2(NUM_CH) | 1;

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic [NUM_CH-1:0] en      = '0;
  logic [NUM_CH-1:0] mode    = '0;
  logic              valid   = 1'b0;
  logic [CH_W-1:0]   wch     = '0;
  logic [DIV_W-1:0]  wdata   = '0;
  logic              sync_in = 1'b0;
  logic              ready;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
    .i_sync_in      (sync_in),
`endif
    .i_en           (en),
    .i_mode         (mode),
    .i_div_wr_valid (valid),
    .o_div_wr_ready (ready),
    .i_div_wr_ch    (wch),
    .i_div_wr_data  (wdata),
    .o_tick         (tick),
    .o_clk_out      (clk_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel counts edges elapsed in its current period and ticks when that reaches the divisor.
  int                m_age    [NUM_CH] = '{default: 0};
  int                m_div    [NUM_CH] = '{default: DEF};
  int                m_shadow [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] m_pend = '0;
  logic [NUM_CH-1:0] m_tick = '0;
  logic [NUM_CH-1:0] m_tgl  = '0;
  logic [NUM_CH-1:0] m_clk  = '0;
  int                cyc    = 0;
  logic              m_acc;
  logic              m_app;

  function automatic logic m_ready();
    int idx;
    idx = int'(wch);
    if (idx >= NUM_CH) return 1'b1;
    return !m_pend[idx];
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_age[i]    = 0;
        m_div[i]    = DEF;
        m_shadow[i] = 0;
      end
      m_pend = '0;
      m_tick = '0;
      m_tgl  = '0;
      m_clk  = '0;
      cyc    = 0;
    end else begin
      m_acc = valid && m_ready();
      for (int i = 0; i < NUM_CH; i++) begin
        m_app = 1'b0;
        if (!en[i] || sync_in) begin
          m_age[i]  = 0;
          m_tick[i] = 1'b0;
          m_tgl[i]  = 1'b0;
          m_app     = m_pend[i];
        end else if (m_div[i] == 0) begin
          m_tick[i] = 1'b0;
          m_app     = m_pend[i];
        end else begin
          m_age[i]  = m_age[i] + 1;
          m_tick[i] = (m_age[i] == m_div[i]);
          if (m_tick[i]) begin
            m_age[i] = 0;
            m_tgl[i] = ~m_tgl[i];
            m_app    = m_pend[i];
          end
        end
        m_clk[i] = mode[i] ? m_tick[i] : m_tgl[i];
        if (m_app) begin
          m_div[i]  = m_shadow[i];
          m_pend[i] = 1'b0;
        end else if (m_acc && (int'(wch) == i)) begin
          m_shadow[i] = int'(wdata);
          m_pend[i]   = 1'b1;
        end
      end
      cyc++;
    end
    #1;
    chk("model_tick",    32'(tick),    32'(m_tick));
    chk("model_clk_out", 32'(clk_out), 32'(m_clk));
    chk("model_ready",   32'(ready),   32'(m_ready()));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    en   = 4'hF;
    mode = 4'h0;
    #12 rst = 1'b0;

    // Default divisor 4, all toggling.
    edges(3);  chk("t1_tick_e3",  32'(tick[0]), 32'd0);
    edges(1);  chk("t1_tick_e4",  32'(tick),    32'hF);
               chk("t1_clk_e4",   32'(clk_out), 32'hF);
    edges(1);  chk("t1_tick_e5",  32'(tick),    32'h0);
               chk("t1_clk_e5",   32'(clk_out), 32'hF);
    edges(3);  chk("t1_tick_e8",  32'(tick),    32'hF);
               chk("t1_clk_e8",   32'(clk_out), 32'h0);
    edges(4);  chk("t1_clk_e12",  32'(clk_out), 32'hF);

    // ch1: load div 5 while disabled, then retarget to 3 mid-period.
    en[1] = 1'b0; valid = 1'b1; wch = 3'd1; wdata = 8'd5;
    edges(1);  chk("t2_ready_pend", 32'(ready), 32'd0);
    valid = 1'b0;
    edges(1);  chk("t2_ready_back", 32'(ready), 32'd1);
    en[1] = 1'b1;
    edges(4);  chk("t2_tick_e4",  32'(tick[1]), 32'd0);
    edges(1);  chk("t2_tick_e5",  32'(tick[1]), 32'd1);
    edges(2);
    valid = 1'b1; wdata = 8'd3;
    edges(1);  chk("t2_ready_drop", 32'(ready), 32'd0);
    valid = 1'b0;
    edges(1);  chk("t2_tick_e9",  32'(tick[1]), 32'd0);
               chk("t2_ready_e9", 32'(ready),   32'd0);
    edges(1);  chk("t2_tick_e10", 32'(tick[1]), 32'd1);
               chk("t2_ready_e10", 32'(ready),  32'd1);
    edges(2);  chk("t2_tick_e12", 32'(tick[1]), 32'd0);
    edges(1);  chk("t2_tick_e13", 32'(tick[1]), 32'd1);
    edges(3);  chk("t2_tick_e16", 32'(tick[1]), 32'd1);

    // Out-of-range channel write is accepted and dropped.
    valid = 1'b1; wch = 3'd5; wdata = 8'd9;
    #1 chk("t_oor_ready", 32'(ready), 32'd1);
    edges(1);  chk("t_oor_ready_after", 32'(ready), 32'd1);
    valid = 1'b0;

    // ch2: halt with div 0 (accepted on a boundary edge), then resume at div 2.
    wch = 3'd2; wdata = 8'd0; valid = 1'b1;
    edges(1);  valid = 1'b0;
    edges(4);  chk("t3_halt_tick", 32'(tick[2]),    32'd1);
               chk("t3_halt_clk",  32'(clk_out[2]), 32'd1);
    edges(4);  chk("t3_held_tick", 32'(tick[2]),    32'd0);
               chk("t3_held_clk",  32'(clk_out[2]), 32'd1);
    wdata = 8'd2; valid = 1'b1;
    edges(1);  valid = 1'b0;
    edges(1);  chk("t3_apply_tick", 32'(tick[2]), 32'd0);
    edges(1);  chk("t3_a1_tick",    32'(tick[2]), 32'd0);
    edges(1);  chk("t3_a2_tick",    32'(tick[2]), 32'd1);
               chk("t3_a2_clk",     32'(clk_out[2]), 32'd0);
    edges(2);  chk("t3_a4_tick",    32'(tick[2]), 32'd1);
               chk("t3_a4_clk",     32'(clk_out[2]), 32'd1);

    // ch0: drop enable on a boundary edge, then re-enable.
    edges(1);
    en[0] = 1'b0;
    edges(1);  chk("t4_dis_tick", 32'(tick[0]),    32'd0);
               chk("t4_dis_clk",  32'(clk_out[0]), 32'd0);
    en[0] = 1'b1;
    edges(3);  chk("t4_re_e3",    32'(tick[0]),    32'd0);
    edges(1);  chk("t4_re_e4",    32'(tick[0]),    32'd1);
               chk("t4_re_clk",   32'(clk_out[0]), 32'd1);

    // ch3: switch to pulse mode.
    mode[3] = 1'b1;
    edges(1);  chk("t5_pulse_lo", 32'(clk_out[3]), 32'd0);
    edges(3);  chk("t5_pulse_hi", 32'(clk_out[3]), 32'd1);
    edges(1);  chk("t5_pulse_lo2", 32'(clk_out[3]), 32'd0);

    // Reset mid-period with a write pending on ch1.
    valid = 1'b1; wch = 3'd1; wdata = 8'd7;
    edges(1);  chk("t6_pend", 32'(ready), 32'd0);
    valid = 1'b0;
    rst = 1'b1;
    #1 chk("t6_rst_tick",  32'(tick),    32'h0);
       chk("t6_rst_clk",   32'(clk_out), 32'h0);
       chk("t6_rst_ready", 32'(ready),   32'd1);
    @(negedge clk) rst = 1'b0;
    edges(3);  chk("t6_e3_tick", 32'(tick),    32'h0);
    edges(1);  chk("t6_e4_tick", 32'(tick),    32'hF);
               chk("t6_e4_clk",  32'(clk_out), 32'hF);
    edges(4);  chk("t6_e8_tick", 32'(tick),    32'hF);
               chk("t6_e8_clk",  32'(clk_out), 32'h8);

`ifdef CLK_DIV_MULTI_SYNC_EN
    // Sync pulse applies ch0=3 and ch1=5 together; they coincide 15 edges later.
    valid = 1'b1; wch = 3'd0; wdata = 8'd3;
    edges(1);  wch = 3'd1; wdata = 8'd5;
    edges(1);  valid = 1'b0; sync_in = 1'b1;
    edges(1);  sync_in = 1'b0;
               chk("t7_sync_tick", 32'(tick[1:0]), 32'd0);
    edges(12); chk("t7_s12", 32'(tick[1:0]), 32'd1);
    edges(2);  chk("t7_s14", 32'(tick[1:0]), 32'd0);
    edges(1);  chk("t7_s15", 32'(tick[1:0]), 32'd3);
`endif

    edges(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
